// File: rtl/tile_map_display.sv
// Play-area tile renderer and tile-state store.
// Keeps a 2-bit state per tile (EMPTY/BLOCK/BREAKING) and takes place/destroy
// commands over a valid/ready handshake. A destroyed tile plays a frame-timed
// breaking animation. Pillar tiles (odd column and odd row) are implied by
// parity and never stored.
// A two-stage pixel pipeline turns the scan position into a sprite select
// and a sprite address.
module tile_map_display #(
   parameter int TILE_LOG2   = 4,
   parameter int X_WALL_L    = 48,
   parameter int X_WALL_R    = 576,
   parameter int Y_WALL_U    = 32,
   parameter int Y_WALL_D    = 448,
   parameter int COLS        = 33,
   parameter int ROWS        = 26,
   parameter int ANIM_FRAMES = 4
) (
   input  logic                                      clk,
   input  logic                                      reset,
   input  logic [9:0]                                x,
   input  logic [9:0]                                y,
   input  logic [9:0]                                x_a,
   input  logic [9:0]                                y_a,
   input  logic                                      frame_tick,
   input  logic                                      cmd_valid,
   output logic                                      cmd_ready,
   input  logic                                      cmd_op,
   input  logic [5:0]                                cmd_col,
   input  logic [4:0]                                cmd_row,
   output logic                                      cmd_err,
   output logic                                      destroy_done,
   output logic                                      tile_on,
   output logic [1:0]                                sprite_sel,
   output logic [$clog2(ANIM_FRAMES)+2*TILE_LOG2-1:0] sprite_addr
);

   localparam int MAP_N   = COLS * ROWS;
   localparam int IDX_W   = $clog2(MAP_N);
   localparam int FRAME_W = $clog2(ANIM_FRAMES);
   localparam int ADDR_W  = FRAME_W + 2 * TILE_LOG2;
   localparam int TC_W    = 10 - TILE_LOG2;

   localparam logic [1:0] T_EMPTY = 2'd0;
   localparam logic [1:0] T_BLOCK = 2'd1;
   localparam logic [1:0] T_BREAK = 2'd2;

   typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_ANIM} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   clr_q, clr_d;
   logic [FRAME_W-1:0] anim_q, anim_d;
   logic [IDX_W-1:0]   lat_idx_q, lat_idx_d;
   logic               err_q, err_d;
   logic               done_q, done_d;

   logic [1:0]         map_q [MAP_N];
   logic               wr_en;
   logic [IDX_W-1:0]   wr_idx;
   logic [1:0]         wr_val;

   // Command-side decode of the addressed tile.
   logic               cmd_in_range, cmd_pillar, accept;
   logic [IDX_W-1:0]   cmd_idx;
   logic [1:0]         cmd_tile;

   assign cmd_in_range = (32'(cmd_col) < COLS) && (32'(cmd_row) < ROWS);
   assign cmd_pillar   = cmd_col[0] & cmd_row[0];
   assign cmd_idx      = IDX_W'(32'(cmd_row) * COLS + 32'(cmd_col));
   assign cmd_tile     = cmd_in_range ? map_q[cmd_idx] : T_EMPTY;

   // While the done pulse is out, hold off ready for one more cycle.
   assign cmd_ready    = (state_q == ST_IDLE) && !done_q;
   assign accept       = cmd_valid & cmd_ready;
   assign cmd_err      = err_q;
   assign destroy_done = done_q;

   // Next-state logic: map clear, command handling and animation timing.
   always_comb begin
      state_d   = state_q;
      clr_d     = clr_q;
      anim_d    = anim_q;
      lat_idx_d = lat_idx_q;
      err_d     = 1'b0;
      done_d    = 1'b0;
      wr_en     = 1'b0;
      wr_idx    = clr_q;
      wr_val    = T_EMPTY;
      case (state_q)
         ST_INIT: begin
            wr_en  = 1'b1;
            wr_idx = clr_q;
            clr_d  = clr_q + 1'b1;
            if (clr_q == IDX_W'(MAP_N - 1)) begin
               clr_d   = '0;
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (accept) begin
               if (!cmd_op) begin
                  if (cmd_in_range && !cmd_pillar && cmd_tile == T_EMPTY) begin
                     wr_en  = 1'b1;
                     wr_idx = cmd_idx;
                     wr_val = T_BLOCK;
                  end else begin
                     err_d = 1'b1;
                  end
               end else begin
                  // A frame_tick arriving together with this destroy is not counted.
                  if (cmd_in_range && cmd_tile == T_BLOCK) begin
                     wr_en     = 1'b1;
                     wr_idx    = cmd_idx;
                     wr_val    = T_BREAK;
                     lat_idx_d = cmd_idx;
                     anim_d    = '0;
                     state_d   = ST_ANIM;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
         end
         ST_ANIM: begin
            if (frame_tick) begin
               if (anim_q == FRAME_W'(ANIM_FRAMES - 1)) begin
                  wr_en   = 1'b1;
                  wr_idx  = lat_idx_q;
                  wr_val  = T_EMPTY;
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  anim_d = anim_q + 1'b1;
               end
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   // Control state register. Reset abandons any animation without a done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_INIT;
         clr_q     <= '0;
         anim_q    <= '0;
         lat_idx_q <= '0;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         clr_q     <= clr_d;
         anim_q    <= anim_d;
         lat_idx_q <= lat_idx_d;
         err_q     <= err_d;
         done_q    <= done_d;
      end
   end

   // Single write port into the tile map. The INIT sweep does the clearing.
   always_ff @(posedge clk) begin
      if (wr_en) map_q[wr_idx] <= wr_val;
   end

   // Stage 1: area test, tile coordinates and in-tile pixel offsets.
   logic                 s1_area_q;
   logic [TC_W-1:0]      s1_col_q, s1_row_q;
   logic [TILE_LOG2-1:0] s1_xo_q, s1_yo_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_area_q <= 1'b0;
         s1_col_q  <= '0;
         s1_row_q  <= '0;
         s1_xo_q   <= '0;
         s1_yo_q   <= '0;
      end else begin
         s1_area_q <= (32'(x) > X_WALL_L) && (32'(x) < X_WALL_R) &&
                      (32'(y) > Y_WALL_U) && (32'(y) < Y_WALL_D);
         s1_col_q  <= x_a[9:TILE_LOG2];
         s1_row_q  <= y_a[9:TILE_LOG2];
         s1_xo_q   <= x_a[TILE_LOG2-1:0];
         s1_yo_q   <= y_a[TILE_LOG2-1:0];
      end
   end

   // Stage 2: map lookup. A pillar wins over whatever the map holds.
   logic              pix_in_range, pix_pillar;
   logic [IDX_W-1:0]  pix_idx;
   logic [1:0]        pix_tile;
   logic              on_d;
   logic [1:0]        sel_d;
   logic [ADDR_W-1:0] addr_d;
   logic              on_q;
   logic [1:0]        sel_q;
   logic [ADDR_W-1:0] addr_q;

   assign pix_in_range = (32'(s1_col_q) < COLS) && (32'(s1_row_q) < ROWS);
   assign pix_pillar   = s1_col_q[0] & s1_row_q[0];
   assign pix_idx      = IDX_W'(32'(s1_row_q) * COLS + 32'(s1_col_q));
   assign pix_tile     = pix_in_range ? map_q[pix_idx] : T_EMPTY;

   // Select the sprite for the looked-up tile. The outputs stay 0 when nothing is drawn.
   always_comb begin
      on_d   = 1'b0;
      sel_d  = 2'd0;
      addr_d = '0;
      if (s1_area_q && pix_in_range) begin
         if (pix_pillar) begin
            on_d   = 1'b1;
            sel_d  = 2'd0;
            addr_d = {{FRAME_W{1'b0}}, s1_yo_q, s1_xo_q};
         end else if (pix_tile == T_BLOCK) begin
            on_d   = 1'b1;
            sel_d  = 2'd1;
            addr_d = {{FRAME_W{1'b0}}, s1_yo_q, s1_xo_q};
         end else if (pix_tile == T_BREAK) begin
            on_d   = 1'b1;
            sel_d  = 2'd2;
            addr_d = {anim_q, s1_yo_q, s1_xo_q};
         end
      end
   end

   // Stage 2 output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         on_q   <= 1'b0;
         sel_q  <= 2'd0;
         addr_q <= '0;
      end else begin
         on_q   <= on_d;
         sel_q  <= sel_d;
         addr_q <= addr_d;
      end
   end

   assign tile_on     = on_q;
   assign sprite_sel  = sel_q;
   assign sprite_addr = addr_q;

endmodule

// File: doc/tile_map_display.md
# tile_map_display

Parametrised play-area tile renderer and tile-state store. It supersedes the fixed pillar overlay. It holds a per-tile state map of EMPTY, BLOCK and BREAKING, and derives pillars from tile parity. It accepts place/destroy commands from game logic over a valid/ready handshake and runs a frame-timed destruction animation. Each cycle it produces a pipelined sprite select and address for the pixel under the VGA scan. It sits between the VGA sync/pixel-coordinate logic and the sprite ROMs / RGB mux.

## Interface
- TILE_LOG2, 4, log2 of tile edge in pixels
- X_WALL_L, 48, left edge of play area (exclusive)
- X_WALL_R, 576, right edge of play area (exclusive)
- Y_WALL_U, 32, top edge of play area (exclusive)
- Y_WALL_D, 448, bottom edge of play area (exclusive)
- COLS, 33, tile columns
- ROWS, 26, tile rows
- ANIM_FRAMES, 4, BREAKING duration in frame ticks (power of 2, ≥2)
- clk  in  1  system clock; one clock only
- reset  in  1  synchronous, active-high
- x, y  in  10  screen pixel coordinate
- x_a, y_a  in  10  play-area pixel coordinate
- frame_tick  in  1  one-cycle pulse per video frame
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_op  in  1  0 = place block, 1 = destroy block
- cmd_col  in  6  target tile column
- cmd_row  in  5  target tile row
- cmd_err  out  1  one-cycle pulse: command rejected
- destroy_done  out  1  one-cycle pulse: destruction finished
- tile_on  out  1  pixel belongs to a pillar/block/breaking tile (latency 2)
- sprite_sel  out  2  0 pillar, 1 block, 2 breaking (latency 2)
- sprite_addr  out  log2(ANIM_FRAMES)+2·TILE_LOG2  {frame, y_a[3:0], x_a[3:0]} (latency 2)

## Operation
- Map: COLS×ROWS entries × 2 bits, register array. Encoding: EMPTY=0, BLOCK=1, BREAKING=2.
- Pillar tile: col[0]=1 and row[0]=1. Pillars are never stored. A pillar has priority over the map.
- FSM states: INIT, IDLE, ANIM.
- INIT: entered on reset. A clear counter writes EMPTY to index 0..COLS·ROWS−1, one entry per cycle. cmd_ready=0. After the last index → IDLE.
- IDLE: cmd_ready=1. A command is accepted on cmd_valid & cmd_ready.
  - Place (op=0): if the tile is in range, not a pillar, and EMPTY → write BLOCK, stay in IDLE. Otherwise the map is unchanged and cmd_err pulses.
  - Destroy (op=1): if the tile is in range and BLOCK → write BREAKING, latch col/row, anim_frame=0, go to ANIM. Otherwise cmd_err pulses and the FSM stays in IDLE.
- ANIM: cmd_ready=0. Each frame_tick increments anim_frame.
  - On a frame_tick with anim_frame=ANIM_FRAMES−1: write EMPTY to the latched tile, pulse destroy_done, go to IDLE.
  - Exactly one tile animates at a time.
- Pixel pipeline:
  - Stage 1 registers: in_area = x>X_WALL_L & x<X_WALL_R & y>Y_WALL_U & y<Y_WALL_D; col=x_a>>TILE_LOG2; row=y_a>>TILE_LOG2; pixel offsets.
  - Stage 2 reads the map, then registers tile_on, sprite_sel and sprite_addr.
  - frame field of sprite_addr = anim_frame when BREAKING, else 0.
  - tile_on=0 when out of area or when col/row is out of range; sprite_sel=0 and sprite_addr=0 then.
- Reset mid-operation: any state → INIT next cycle. An animation in progress is abandoned and the map is cleared. No destroy_done pulse is issued.

## Timing
- Reset values: cmd_ready=0, cmd_err=0, destroy_done=0, tile_on=0, sprite_sel=0, sprite_addr=0, state=INIT.
- INIT lasts COLS·ROWS cycles after reset deasserts. cmd_ready rises on cycle COLS·ROWS.
- Map writes take effect the cycle after acceptance. cmd_err is asserted the cycle after acceptance.
- cmd_ready drops the cycle after an accepted destroy. It rises the cycle after destroy_done.
- destroy_done is registered and asserted in the cycle after the terminating frame_tick.
- Pixel path latency is 2 clk. A map write at edge N is visible on the pixel outputs from edge N+2 for a pixel presented at N+1.
- frame_tick coincident with acceptance of a destroy is not counted. Counting starts in ANIM.
- frame_tick in IDLE/INIT is ignored.

## Test plan
- Reset released → cmd_ready low for exactly 858 cycles, then high. Sweep all pixels: tile_on=1 only at pillar tiles (e.g. x_a=16..31, y_a=16..31).
- Place (col 2, row 3) → no cmd_err. Pixel x=48+32+5, y=32+48+7 two cycles later → tile_on=1, sprite_sel=1, sprite_addr=0x075.
- Place on pillar (1,1), re-place (2,3), col 40 → cmd_err pulse each, map unchanged.
- Destroy (2,3) → sprite_sel=2. Frame field steps 0,1,2,3 on successive frame_ticks. destroy_done arrives one cycle after the 4th tick, then tile_on=0, and cmd_ready returns.
- Destroy EMPTY tile (4,4) → cmd_err, no ANIM. cmd_valid held during ANIM → not accepted until cmd_ready returns.
- Reset asserted after 2 frame ticks in ANIM → INIT, no destroy_done, map cleared, tile (2,3) reads EMPTY afterwards.
